// File: rtl/hilo_sequencer.sv
// Issue-side sequencer for the Hi/Lo multiply unit: accepts one Hi/Lo op from decode,
// runs a 32-step shift-add multiply and drives the unit's write/accumulate/mux controls.
module hilo_sequencer #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Op_valid,
    input  logic [2:0]  Op,
    output logic        Op_ready,
    input  logic [31:0] Rs_val,
    input  logic [31:0] Rt_val,
    input  logic        Read_req,
    input  logic        Read_hi,
    output logic        Stall,
    output logic [31:0] Prod_hi,
    output logic [31:0] Prod_lo,
    output logic        WriteLo,
    output logic        WriteHi,
    output logic        Add64,
    output logic        HiLo_sel,
    output logic        HiRsSel,
    output logic        HiOrLo,
    output logic        Busy,
    output logic        Done
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MUL   = 2'd1;
    localparam logic [1:0] FIX   = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MADD  = 3'd3;
    localparam logic [2:0] OP_MADDU = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    logic [1:0]       state;
    logic [2:0]       opLatch;
    logic             negFlag;
    logic [31:0]      mcand;
    logic [31:0]      mplier;
    logic [63:0]      acc;
    logic [CNT_W-1:0] count;

    logic             opAccept;
    logic             opSigned;
    logic             opMove;
    logic [32:0]      partialSum;

    function automatic logic [31:0] absVal(input logic signed [31:0] v);
        if (v < 0)
            absVal = $unsigned(-v);
        else
            absVal = $unsigned(v);
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        neg64 = ~v + 64'd1;
    endfunction

    assign opAccept = Op_valid && (state == IDLE) && (Op != OP_NOP);
    assign opSigned = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB);
    assign opMove   = (Op == OP_MTHI) || (Op == OP_MTLO);

    // Add the multiplicand into the top 33 bits before the right shift
    assign partialSum = {1'b0, acc[63:32]} + {1'b0, (mplier[0] ? mcand : 32'd0)};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            opLatch <= OP_NOP;
            negFlag <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (opAccept) begin
                        opLatch <= Op;
                        if (opMove) begin
                            // MTHI/MTLO carry rs straight to the product outputs
                            acc     <= {32'd0, Rs_val};
                            negFlag <= 1'b0;
                            state   <= WRITE;
                        end else begin
                            mcand   <= opSigned ? absVal($signed(Rs_val)) : Rs_val;
                            mplier  <= opSigned ? absVal($signed(Rt_val)) : Rt_val;
                            acc     <= '0;
                            count   <= '0;
                            negFlag <= (opSigned && (Rs_val[31] != Rt_val[31])) ^ (Op == OP_MSUB);
                            state   <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc    <= {partialSum, acc[31:1]};
                    mplier <= {1'b0, mplier[31:1]};
                    count  <= count + 1'b1;
                    if (count == CNT_W'(MUL_CYCLES - 1))
                        state <= FIX;
                end
                FIX: begin
                    state <= WRITE;
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Accumulator is frozen outside MUL, so the sign-fixed product is stable from FIX to WRITE
    always_comb begin
        if (negFlag)
            {Prod_hi, Prod_lo} = neg64(acc);
        else
            {Prod_hi, Prod_lo} = acc;
    end

    always_comb begin
        Op_ready = (state == IDLE);
        Busy     = (state != IDLE);
        Stall    = Read_req && (state != IDLE);
        HiOrLo   = Read_hi;
        WriteLo  = 1'b0;
        WriteHi  = 1'b0;
        Add64    = 1'b0;
        HiLo_sel = 1'b0;
        HiRsSel  = 1'b0;
        Done     = 1'b0;
        if (state == WRITE) begin
            Done = 1'b1;
            case (opLatch)
                OP_MULT, OP_MULTU: begin
                    WriteLo = 1'b1;
                    WriteHi = 1'b1;
                end
                OP_MADD, OP_MADDU, OP_MSUB: begin
                    WriteLo  = 1'b1;
                    WriteHi  = 1'b1;
                    Add64    = 1'b1;
                    HiLo_sel = 1'b1;
                end
                OP_MTHI: begin
                    WriteHi = 1'b1;
                    HiRsSel = 1'b1;
                end
                OP_MTLO: begin
                    WriteLo = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer: a scoreboard queue of expected WRITE cycles is drained by a
// monitor that also keeps a behavioural Hi/Lo register driven by the sequencer's controls.
module tb_hilo_sequencer;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Op_valid = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic        Op_ready;
    logic [31:0] Rs_val = '0;
    logic [31:0] Rt_val = '0;
    logic        Read_req = 1'b0;
    logic        Read_hi = 1'b0;
    logic        Stall;
    logic [31:0] Prod_hi;
    logic [31:0] Prod_lo;
    logic        WriteLo;
    logic        WriteHi;
    logic        Add64;
    logic        HiLo_sel;
    logic        HiRsSel;
    logic        HiOrLo;
    logic        Busy;
    logic        Done;

    hilo_sequencer #(.MUL_CYCLES(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Op_valid(Op_valid), .Op(Op), .Op_ready(Op_ready),
        .Rs_val(Rs_val), .Rt_val(Rt_val), .Read_req(Read_req), .Read_hi(Read_hi),
        .Stall(Stall), .Prod_hi(Prod_hi), .Prod_lo(Prod_lo), .WriteLo(WriteLo),
        .WriteHi(WriteHi), .Add64(Add64), .HiLo_sel(HiLo_sel), .HiRsSel(HiRsSel),
        .HiOrLo(HiOrLo), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          cycle;
        logic [4:0]  ctrl;   // {WriteLo, WriteHi, Add64, HiLo_sel, HiRsSel}
        logic [63:0] prod;
        logic [63:0] mask;
        logic [31:0] rs;
    } sbEnt_t;

    sbEnt_t      sbQ[$];
    sbEnt_t      mEnt;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic [63:0] mSum;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every WRITE pulse must match the oldest expectation; no writes elsewhere
    always @(negedge Clk) begin
        if (Rst_n && Done) begin
            if (sbQ.size() == 0) begin
                chk("unexpected_done", 64'(Done), 64'd0);
            end else begin
                mEnt = sbQ.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mEnt.cycle));
                chk("done_ctrl", 64'({WriteLo, WriteHi, Add64, HiLo_sel, HiRsSel}), 64'(mEnt.ctrl));
                chk("done_prod", {Prod_hi, Prod_lo} & mEnt.mask, mEnt.prod & mEnt.mask);
                mSum = HiLo_sel ? ({mHi, mLo} + {Prod_hi, Prod_lo}) : {Prod_hi, Prod_lo};
                if (WriteHi) mHi = HiRsSel ? mEnt.rs : mSum[63:32];
                if (WriteLo) mLo = mSum[31:0];
            end
        end else begin
            chk("writes_outside_write", 64'({WriteLo, WriteHi, Add64, HiRsSel}), 64'd0);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input int lat, input logic [4:0] ctrl, input logic [63:0] prod,
                         input logic [63:0] mask, input bit doPush, output int accCyc);
        sbEnt_t e;
        int waited;
        @(negedge Clk);
        Op_valid = 1'b1;
        Op = op;
        Rs_val = rs;
        Rt_val = rt;
        waited = 0;
        while (!Op_ready && waited < 100) begin
            @(negedge Clk);
            waited++;
        end
        if (!Op_ready) chk("accept_timeout", 64'(Op_ready), 64'd1);
        accCyc = cyc;
        if (doPush) begin
            e.cycle = accCyc + lat;
            e.ctrl = ctrl;
            e.prod = prod;
            e.mask = mask;
            e.rs = rs;
            sbQ.push_back(e);
        end
        @(negedge Clk);
        Op_valid = 1'b0;
        Op = 3'd0;
    endtask

    task automatic waitIdle();
        int waited = 0;
        while (!Op_ready && waited < 100) begin
            @(negedge Clk);
            waited++;
        end
        if (!Op_ready) chk("idle_timeout", 64'(Op_ready), 64'd1);
    endtask

    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        int a;
        #12;
        chk("rst_ready", 64'(Op_ready), 64'd1);
        chk("rst_busy_done_stall", 64'({Busy, Done, Stall}), 64'd0);
        chk("rst_prod", {Prod_hi, Prod_lo}, 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Reset in the middle of a MULT aborts it with no write
        issue(3'd1, 32'd9, 32'd9, 34, 5'b11000, 64'd81, ALL, 1'b0, a);
        while (cyc < a + 10) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(Op_ready), 64'd1);
        chk("abort_outs", 64'({Busy, Done, WriteLo, WriteHi, Add64, HiLo_sel, HiRsSel}), 64'd0);
        chk("abort_prod", {Prod_hi, Prod_lo}, 64'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (40) @(negedge Clk);
        chk("abort_no_hilo_write", {mHi, mLo}, 64'd0);

        // MULTU max operands
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 5'b11000, 64'hFFFF_FFFE_0000_0001, ALL, 1'b1, a);
        chk("mul_ready_low", 64'({Op_ready, Busy}), 64'b01);
        waitIdle();
        chk("multu_ready_cycle", 64'(cyc), 64'(a + 35));
        chk("multu_hilo", {mHi, mLo}, 64'hFFFF_FFFE_0000_0001);

        // Signed MULT with negative rs, then MSUB of the same operands
        issue(3'd1, 32'hFFFF_FFFD, 32'd7, 34, 5'b11000, 64'hFFFF_FFFF_FFFF_FFEB, ALL, 1'b1, a);
        waitIdle();
        chk("mult_neg_hilo", {mHi, mLo}, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(3'd7, 32'hFFFF_FFFD, 32'd7, 34, 5'b11110, 64'h0000_0000_0000_0015, ALL, 1'b1, a);
        waitIdle();
        chk("msub_hilo_wrap", {mHi, mLo}, 64'd0);

        // MTHI, then an MFHI read in IDLE
        issue(3'd5, 32'h1234_5678, 32'd0, 1, 5'b01001, 64'd0, 64'd0, 1'b1, a);
        waitIdle();
        chk("mthi_ready_cycle", 64'(cyc), 64'(a + 2));
        Read_req = 1'b1;
        Read_hi = 1'b1;
        #1;
        chk("mfhi_nostall", 64'({Stall, HiOrLo}), 64'b01);
        chk("mfhi_value", 64'(mHi), 64'h1234_5678);
        @(negedge Clk);
        Read_req = 1'b0;
        Read_hi = 1'b0;

        // MTLO, then MADD with an MFLO read stalled across the operation
        issue(3'd6, 32'h0000_0010, 32'd0, 1, 5'b10000, 64'h0000_0000_0000_0010, 64'h0000_0000_FFFF_FFFF, 1'b1, a);
        waitIdle();
        chk("mtlo_lo", 64'(mLo), 64'h10);
        issue(3'd3, 32'd5, 32'd6, 34, 5'b11110, 64'h1E, ALL, 1'b1, a);
        while (cyc < a + 3) @(negedge Clk);
        Read_req = 1'b1;
        Read_hi = 1'b0;
        while (cyc <= a + 35) begin
            #1;
            chk("madd_stall", 64'(Stall), 64'(cyc <= a + 34));
            @(negedge Clk);
        end
        chk("madd_hiorlo", 64'(HiOrLo), 64'd0);
        Read_req = 1'b0;
        chk("madd_hilo", {mHi, mLo}, {32'h1234_5678, 32'h0000_002E});

        // MTLO presented during a MULT waits until IDLE
        issue(3'd1, 32'd2, 32'd3, 34, 5'b11000, 64'd6, ALL, 1'b1, a);
        issue(3'd6, 32'h0000_ABCD, 32'd0, 1, 5'b10000, 64'h0000_ABCD, 64'h0000_0000_FFFF_FFFF, 1'b1, a);
        waitIdle();
        chk("held_mtlo_hilo", {mHi, mLo}, 64'h0000_0000_0000_ABCD);

        // NOP in IDLE leaves the sequencer idle
        @(negedge Clk);
        Op_valid = 1'b1;
        Op = 3'd0;
        Rs_val = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge Clk);
            chk("nop_idle", 64'({Op_ready, Busy}), 64'b10);
        end
        Op_valid = 1'b0;

        repeat (5) @(negedge Clk);
        chk("sb_drained", 64'(sbQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hilo_sequencer.md
Name: hilo_sequencer

Overview:
- Issue-side controller for the Hi/Lo multiplication unit.
- Accepts one Hi/Lo-class instruction at a time from decode, runs a 32-cycle iterative shift-add multiply, and presents the 64-bit product on Prod_hi/Prod_lo (the unit's ALU_hi/ALU_out inputs).
- Sequences the unit's write, accumulate and mux controls, and stalls MFHI/MFLO reads while an operation is in flight.

Parameters:
- MUL_CYCLES, 32, iterations of the shift-add loop; fixed at 32 for 32-bit operands.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Op_valid  in  1  decode presents an op.
- Op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MTHI, 6 MTLO, 7 MSUB.
- Op_ready  out  1  high only in IDLE.
- Rs_val  in  32  rs operand; the MTHI/MTLO source.
- Rt_val  in  32  rt operand.
- Read_req  in  1  MFHI/MFLO in the execute stage.
- Read_hi  in  1  1 = MFHI, 0 = MFLO.
- Stall  out  1  hold the pipeline; the read cannot be served yet.
- Prod_hi  out  32  product high word, or 0.
- Prod_lo  out  32  product low word, or Rs_val for MTLO.
- WriteLo  out  1  Lo write enable for the unit.
- WriteHi  out  1  Hi write enable for the unit.
- Add64  out  1  adder enable; high for accumulate ops.
- HiLo_sel  out  1  0 = plain product, 1 = Hi/Lo + product.
- HiRsSel  out  1  0 = Hi written from the product path, 1 = Hi written from rs.
- HiOrLo  out  1  read mux select, 1 = Hi.
- Busy  out  1  state != IDLE.
- Done  out  1  one-cycle pulse in the WRITE state.

Behaviour:
- Reset: state = IDLE; all registers and all outputs 0 except Op_ready = 1.
  - Reset asserted mid-operation aborts the op; no Hi/Lo write occurs.
- States: IDLE, MUL, FIX, WRITE.
- Handshake: an op is accepted on a cycle where Op_valid & Op_ready and Op != 0. NOP is ignored and keeps the sequencer in IDLE.
- IDLE on accept:
  - Latches op, Rs_val, Rt_val.
  - MTHI/MTLO go to WRITE.
  - Multiply ops go to MUL: load the magnitudes |Rs|, |Rt| (signed ops only; unsigned ops load the raw values), clear the 64-bit accumulator, set counter = 0.
- MUL: each cycle, if multiplier bit0 = 1, add the multiplicand into the upper 33 bits of the accumulator; then shift right by 1. After MUL_CYCLES iterations, go to FIX.
- FIX: the product is negated (64-bit two's complement) when either of these holds, but not both:
  - the op is signed and the sign bits of Rs and Rt differ;
  - the op is MSUB.
  - Then go to WRITE.
- Latencies:
  - Multiply ops: accept at cycle 0, MUL in cycles 1–32, FIX in cycle 33, WRITE in cycle 34. Hi/Lo are updated at the end of cycle 34, and Op_ready returns in cycle 35.
  - MTHI/MTLO: WRITE in cycle 1.
- WRITE outputs, held for exactly one cycle, with Done = 1:
  - MULT/MULTU: WriteLo = 1, WriteHi = 1, HiLo_sel = 0, Add64 = 0, HiRsSel = 0.
  - MADD/MADDU/MSUB: same as MULT/MULTU but HiLo_sel = 1 and Add64 = 1; 64-bit wrap-around, with no overflow flag.
  - MTHI: WriteHi = 1, HiRsSel = 1, WriteLo = 0.
  - MTLO: WriteLo = 1, Prod_lo = Rs latch, HiLo_sel = 0, WriteHi = 0.
- Outside WRITE: WriteLo = WriteHi = Add64 = 0.
- Prod_hi/Prod_lo are held stable from FIX through WRITE.
- Read handling: Stall = Read_req & (state != IDLE). HiOrLo = Read_hi, combinationally.
  - Read_req together with an op accept in IDLE: the read is served that cycle from the old Hi/Lo, with no stall.
  - During WRITE, Stall = 1; the read is served in the following IDLE cycle with the new value.
- Op_valid while Busy: ignored. Decode must hold the op until Op_ready.

Test Plan:
1. Reset mid-MUL: Rst_n = 0 at cycle 10 of a MULT → all outputs 0 immediately, no WriteLo/WriteHi pulse, Op_ready = 1 after release.
2. MULTU Rs = 0xFFFFFFFF, Rt = 0xFFFFFFFF → WRITE at cycle 34 with Prod_hi = 0xFFFFFFFE, Prod_lo = 0x00000001, WriteLo = WriteHi = 1, HiLo_sel = 0; Hi/Lo hold these values afterwards.
3. MULT Rs = 0xFFFFFFFD (−3), Rt = 7 → Prod = 0xFFFFFFFF_FFFFFFEB; with MSUB on the same operands → Prod = 0x00000000_00000015, HiLo_sel = 1, Add64 = 1.
4. MTHI Rs = 0x12345678 → cycle 1: WriteHi = 1, HiRsSel = 1, WriteLo = 0; Done for one cycle; MFHI afterwards reads 0x12345678.
5. MADD issued, then Read_req (MFLO) in cycle 3 → Stall = 1 through cycle 34, 0 in cycle 35, HiOrLo = 0; Lo equals old Lo + product.
6. Op_valid = 1 with Op = MTLO during MUL → ignored (Op_ready = 0, no WriteLo) until IDLE; NOP in IDLE → no state change.
